// File: rtl/wino_f23_conv.sv
// wino_f23_conv -- Winograd F(2,3) convolution engine for a 3-row sliding window.
//
// Each accepted 3x4 pixel window yields two adjacent outputs {y0, y1} of a
// 3x3 convolution. The kernel is pre-transformed when it is loaded. The data
// side runs one pipeline step per FSM state: capture, transform, multiply,
// reduce. Each window advances the upstream read pointer by two pixels. At the
// end of a line, two extra advances re-align the pointer to the next line.
//
// Parameters
//   W   line width in pixels (even, >= 4)
//   OW  signed width of each output pixel
// Ports
//   i_clk, i_rst   clock; synchronous active-high reset
//   i_win          3x4 unsigned 8-bit window; row r, pixel j at [(2-r)*32+(3-j)*8 +: 8]
//   i_win_valid    upstream holds at least three complete lines
//   o_rd_data      one-cycle pulse; advances the upstream read pointer by one
//   i_k_load       kernel load strobe (honoured only while idle)
//   i_k_data       3x3 signed 8-bit kernel; g[r][c] at [(8-3r-c)*8 +: 8]
//   o_data         {y0, y1}, held until accepted
//   o_valid        o_data valid
//   i_ready        downstream accept
//   o_row_last     qualifies o_valid; last output pair of a line
//   o_busy         engine is not idle
// Build option
//   WINO_RELU_EN   when defined, negative y0/y1 are clamped to zero
module wino_f23_conv #(
  parameter int W  = 512,
  parameter int OW = 20
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [95:0]     i_win,
  input  logic            i_win_valid,
  output logic            o_rd_data,
  input  logic            i_k_load,
  input  logic [71:0]     i_k_data,
  output logic [2*OW-1:0] o_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_row_last,
  output logic            o_busy
);

  localparam int CW = $clog2(W / 2);
  localparam int MW = 22;      // each of the three 20-bit products plus growth for their sum
  localparam int SW = MW + 2;  // room for the three-term output sum
  localparam logic [CW-1:0] LAST_WIN = CW'(W / 2 - 2);

  typedef enum logic [3:0] {
    IDLE, ADV0, ADV1, XFORM, MULT, SUM, OUT, SKIP0, SKIP1
  } state_t;

  state_t                state_q, state_d;
  logic [95:0]           win_q;
  logic signed [9:0]     v_q [3][4];
  logic signed [9:0]     v_d [3][4];
  logic signed [9:0]     u_q [3][4];
  logic signed [9:0]     u_d [3][4];
  logic signed [MW-1:0]  m_q [4];
  logic signed [MW-1:0]  m_d [4];
  logic [CW-1:0]         cnt_q;
  logic [2*OW-1:0]       data_q, data_d;
  logic signed [SW-1:0]  s0, s1, y0, y1;
  logic                  win_last, load_k, capture, xfer;

  // Pixel j of row r, zero-extended into the signed 10-bit transform domain.
  function automatic logic signed [9:0] px(input logic [95:0] w, input int r, input int j);
    return $signed({2'b00, w[(2-r)*32 + (3-j)*8 +: 8]});
  endfunction

  // Kernel tap g[r][c], sign-extended to 10 bits.
  function automatic logic signed [9:0] kg(input logic [71:0] k, input int r, input int c);
    logic [7:0] b;
    b = k[(8-3*r-c)*8 +: 8];
    return $signed({{2{b[7]}}, b});
  endfunction

  assign win_last = (cnt_q == LAST_WIN);
  assign xfer     = (state_q == OUT) && i_ready;

  // NOTE: every output of this block is given a default before the case so
  // that no path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    load_k     = 1'b0;
    capture    = 1'b0;
    o_valid    = 1'b0;
    o_rd_data  = 1'b0;
    o_row_last = 1'b0;
    o_busy     = 1'b1;
    case (state_q)
      IDLE: begin
        o_busy = 1'b0;
        // A kernel load takes priority: no window is captured in that cycle.
        if (i_k_load) begin
          load_k = 1'b1;
        end else if (i_win_valid) begin
          capture = 1'b1;
          state_d = ADV0;
        end
      end
      ADV0:  begin o_rd_data = 1'b1; state_d = ADV1;  end
      ADV1:  begin o_rd_data = 1'b1; state_d = XFORM; end
      XFORM: state_d = MULT;
      MULT:  state_d = SUM;
      SUM:   state_d = OUT;
      OUT: begin
        o_valid    = 1'b1;
        o_row_last = win_last;
        if (i_ready) state_d = win_last ? SKIP0 : IDLE;
      end
      SKIP0: begin o_rd_data = 1'b1; state_d = SKIP1; end
      SKIP1: begin o_rd_data = 1'b1; state_d = IDLE;  end
      default: state_d = IDLE;
    endcase
  end

  // Input transform of the captured window, and kernel transform (scaled by 2
  // so that it stays integer) applied to the incoming kernel at load time.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      u_d[r][0] = px(win_q, r, 0) - px(win_q, r, 2);
      u_d[r][1] = px(win_q, r, 1) + px(win_q, r, 2);
      u_d[r][2] = px(win_q, r, 2) - px(win_q, r, 1);
      u_d[r][3] = px(win_q, r, 1) - px(win_q, r, 3);
      v_d[r][0] = kg(i_k_data, r, 0) <<< 1;
      v_d[r][1] = kg(i_k_data, r, 0) + kg(i_k_data, r, 1) + kg(i_k_data, r, 2);
      v_d[r][2] = kg(i_k_data, r, 0) - kg(i_k_data, r, 1) + kg(i_k_data, r, 2);
      v_d[r][3] = kg(i_k_data, r, 2) <<< 1;
    end
  end

  // Element-wise products summed over the three rows.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      m_d[k] = '0;
      for (int r = 0; r < 3; r++) begin
        m_d[k] = m_d[k] + MW'(u_q[r][k]) * MW'(v_q[r][k]);
      end
    end
  end

  // Output transform. The kernel was scaled by 2, so both sums are even and
  // the arithmetic shift is exact.
  always_comb begin
    s0 = SW'(m_q[0]) + SW'(m_q[1]) + SW'(m_q[2]);
    s1 = SW'(m_q[1]) - SW'(m_q[2]) - SW'(m_q[3]);
    y0 = s0 >>> 1;
    y1 = s1 >>> 1;
`ifdef WINO_RELU_EN
    if (y0[SW-1]) y0 = '0;
    if (y1[SW-1]) y1 = '0;
`endif
    data_d = {OW'(y0), OW'(y1)};
  end

  // NOTE: state is updated with non-blocking assignments, so every register
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the kernel, counter and output must read back as zero after
      // reset. The pipeline scratch arrays are cleared as well, so they never
      // hold stale or unknown data.
      state_q <= IDLE;
      win_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int k = 0; k < 4; k++) begin
          v_q[r][k] <= '0;
          u_q[r][k] <= '0;
        end
      end
      for (int k = 0; k < 4; k++) m_q[k] <= '0;
    end else begin
      state_q <= state_d;
      if (load_k)           v_q    <= v_d;
      if (capture)          win_q  <= i_win;
      if (state_q == XFORM) u_q    <= u_d;
      if (state_q == MULT)  m_q    <= m_d;
      if (state_q == SUM)   data_q <= data_d;
      if (xfer)             cnt_q  <= win_last ? '0 : cnt_q + CW'(1);
    end
  end

  assign o_data = data_q;

endmodule
